// File: rtl/svlog_push_crc_fsm.sv
// Merges the masked input channels, in ascending channel order, into one frame and can append a CRC-16-CCITT.
// Latency: PUSH beats pass through with zero latency; CRC beats come from a register; done/err come from the state.
// Backpressure: out_ready passes straight to in_ready of the current channel; the CRC beats hold until out_ready is high.
module svlog_push_crc_fsm #(
    parameter int NUM_CH  = 2,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     start,
    input  logic [NUM_CH-1:0]        ch_mask,
    input  logic                     crc_en,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_last,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
    localparam bit CRC_TWO = (DATA_W == 8);

    typedef enum logic [2:0] {IDLE, PUSH, CRC, DONE, ERR} state_t;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     cur_q, cur_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic                crc_en_q, crc_en_d;
    logic [15:0]         crc_q, crc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                crc_idx_q, crc_idx_d;

    logic [DATA_W-1:0]   ch_dat [NUM_CH];
    logic [CH_W-1:0]     first_ch, nxt_ch;
    logic                has_nxt;
    logic                last_beat;
    logic [31:0]         crc_word;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
        assign ch_dat[k] = in_data[k*DATA_W +: DATA_W];
    end

    // Bitwise CRC-16-CCITT, MSB first, no reflection.
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [DATA_W-1:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction

    // Descending scans so the lowest qualifying channel wins.
    always_comb begin
        first_ch = '0;
        nxt_ch   = cur_q;
        has_nxt  = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (ch_mask[k]) begin
                first_ch = CH_W'(k);
            end
            if (mask_q[k] && (k > int'(cur_q))) begin
                nxt_ch  = CH_W'(k);
                has_nxt = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        mask_d    = mask_q;
        crc_en_d  = crc_en_q;
        crc_d     = crc_q;
        cnt_d     = cnt_q;
        crc_idx_d = crc_idx_q;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        in_ready  = '0;
        last_beat = 1'b0;
        crc_word  = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mask_d    = ch_mask;
                    crc_en_d  = crc_en;
                    crc_d     = 16'hFFFF;
                    cur_d     = first_ch;
                    cnt_d     = '0;
                    crc_idx_d = 1'b0;
                    if (|ch_mask) begin
                        state_d = PUSH;
                    end else if (crc_en) begin
                        state_d = CRC;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            PUSH: begin
                out_valid       = in_valid[cur_q];
                out_data        = ch_dat[cur_q];
                in_ready[cur_q] = out_ready;
                out_last        = in_last[cur_q] & ~has_nxt & ~crc_en_q;
                if (out_valid && out_ready) begin
                    crc_d = crc_step(crc_q, out_data);
                    cnt_d = '0;
                    if (in_last[cur_q]) begin
                        if (has_nxt) begin
                            cur_d = nxt_ch;
                        end else if (crc_en_q) begin
                            state_d   = CRC;
                            crc_idx_d = 1'b0;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end else if (TIMEOUT > 0) begin
                    if (cnt_q == TO_VAL) begin
                        state_d = ERR;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            CRC: begin
                out_valid = 1'b1;
                if (CRC_TWO) begin
                    crc_word = crc_idx_q ? {24'h0, crc_q[7:0]} : {24'h0, crc_q[15:8]};
                end else begin
                    crc_word = {16'h0, crc_q};
                end
                out_data  = crc_word[DATA_W-1:0];
                last_beat = !CRC_TWO || crc_idx_q;
                out_last  = last_beat;
                if (out_ready) begin
                    cnt_d = '0;
                    if (last_beat) begin
                        state_d = DONE;
                    end else begin
                        crc_idx_d = 1'b1;
                    end
                end else if (TIMEOUT > 0) begin
                    if (cnt_q == TO_VAL) begin
                        state_d = ERR;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cur_q     <= '0;
            mask_q    <= '0;
            crc_en_q  <= 1'b0;
            crc_q     <= 16'hFFFF;
            cnt_q     <= '0;
            crc_idx_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            mask_q    <= mask_d;
            crc_en_q  <= crc_en_d;
            crc_q     <= crc_d;
            cnt_q     <= cnt_d;
            crc_idx_q <= crc_idx_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign err  = (state_q == ERR);

endmodule

// File: tb/tb_svlog_push_crc_fsm.sv
// Directed bench for svlog_push_crc_fsm: 4 channels, 8-bit beats, short timeout.
module tb_svlog_push_crc_fsm;
    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [3:0]  ch_mask;
    logic        crc_en;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_last;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    // One queue per source lane; bit 8 is the last flag.
    logic [8:0] qb [4][$];
    logic [8:0] obs [$];
    logic [8:0] exp_q [$];
    int done_cnt, err_cnt, done_cyc, err_cyc, last_acc, bad_rdy;
    logic post_busy, post_pulse;

    svlog_push_crc_fsm #(.NUM_CH(4), .DATA_W(8), .TIMEOUT(4)) dut (
        .clk(clk), .rstn(rstn), .start(start), .ch_mask(ch_mask), .crc_en(crc_en),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) begin
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        end
        return r;
    endfunction

    task automatic drive_lanes();
        for (int k = 0; k < 4; k++) begin
            in_valid[k]       = (qb[k].size() > 0);
            in_data[k*8 +: 8] = (qb[k].size() > 0) ? qb[k][0][7:0] : 8'h00;
            in_last[k]        = (qb[k].size() > 0) ? qb[k][0][8] : 1'b0;
        end
    endtask

    // rdy_mode: 0 = always ready, 1 = toggles every cycle.
    task automatic run_frame(input logic [3:0] mask, input logic ce, input int rdy_mode, input int max_cyc);
        int  c;
        bit  fin;
        obs.delete();
        done_cnt = 0; err_cnt = 0; done_cyc = -1; err_cyc = -1; last_acc = -1; bad_rdy = 0;
        @(negedge clk);
        start = 1'b1; ch_mask = mask; crc_en = ce; out_ready = 1'b1;
        drive_lanes();
        @(posedge clk);
        #1;
        start = 1'b0; ch_mask = ~mask; crc_en = ~ce;
        c = 0; fin = 0;
        while (!fin && c < max_cyc) begin
            @(negedge clk);
            c++;
            out_ready = (rdy_mode == 0) ? 1'b1 : c[0];
            drive_lanes();
            #1;
            if (((in_ready & ~mask) != 4'h0) || ($countones(in_ready) > 1)) bad_rdy++;
            if (out_valid && out_ready) begin
                obs.push_back({out_last, out_data});
                last_acc = c;
            end
            for (int k = 0; k < 4; k++) begin
                if (in_valid[k] && in_ready[k]) void'(qb[k].pop_front());
            end
            if (done) begin done_cnt++; done_cyc = c; fin = 1; end
            if (err)  begin err_cnt++;  err_cyc  = c; fin = 1; end
        end
        if (!fin) chk("frame_bound", 32'd0, 32'd1);
        @(negedge clk);
        #1;
        post_busy  = busy;
        post_pulse = done | err;
    endtask

    task automatic cmp_obs(input string tag);
        chk({tag, "_len"}, obs.size(), exp_q.size());
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s_b%0d", tag, i), {23'h0, obs[i]}, {23'h0, exp_q[i]});
        end
    endtask

    initial begin
        logic [15:0] crc;
        logic        saw;
        rstn = 1'b0; start = 1'b0; ch_mask = '0; crc_en = 1'b0;
        in_valid = '0; in_data = '0; in_last = '0; out_ready = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // "123456789" on channel 0, CRC appended.
        for (int i = 0; i < 9; i++) qb[0].push_back({(i == 8), 8'h31 + 8'(i)});
        run_frame(4'b0001, 1'b1, 0, 40);
        exp_q.delete();
        for (int i = 0; i < 9; i++) exp_q.push_back({1'b0, 8'h31 + 8'(i)});
        exp_q.push_back(9'h029);
        exp_q.push_back(9'h1B1);
        cmp_obs("crc");
        chk("crc_done_cnt", done_cnt, 1);
        chk("crc_done_lag", done_cyc - last_acc, 1);
        chk("crc_post", {post_busy, post_pulse}, 2'b00);

        // Channel order, channels 1 and 3 valid but unmasked.
        qb[0] = '{9'h0A0, 9'h1A1};
        qb[1] = '{9'h1B0};
        qb[2] = '{9'h0C0, 9'h0C1, 9'h1C2};
        qb[3] = '{9'h1D0};
        run_frame(4'b0101, 1'b0, 0, 40);
        exp_q = '{9'h0A0, 9'h0A1, 9'h0C0, 9'h0C1, 9'h1C2};
        cmp_obs("order");
        chk("order_bad_rdy", bad_rdy, 0);
        chk("order_unused", qb[1].size() + qb[3].size(), 2);
        chk("order_done_cnt", done_cnt, 1);
        qb[1].delete(); qb[3].delete();

        // Backpressure: out_ready toggling over a 4-beat frame.
        qb[0] = '{9'h011, 9'h122};
        qb[1] = '{9'h033, 9'h144};
        run_frame(4'b0011, 1'b1, 1, 60);
        crc = 16'hFFFF;
        crc = crc_ref(crc, 8'h11); crc = crc_ref(crc, 8'h22);
        crc = crc_ref(crc, 8'h33); crc = crc_ref(crc, 8'h44);
        exp_q = '{9'h011, 9'h022, 9'h033, 9'h044};
        exp_q.push_back({1'b0, crc[15:8]});
        exp_q.push_back({1'b1, crc[7:0]});
        cmp_obs("bp");
        chk("bp_err", err_cnt, 0);
        chk("bp_done_cnt", done_cnt, 1);

        // Empty frames.
        run_frame(4'b0000, 1'b1, 0, 20);
        exp_q = '{9'h0FF, 9'h1FF};
        cmp_obs("empty_crc");
        chk("empty_crc_done_cyc", done_cyc, 3);
        run_frame(4'b0000, 1'b0, 0, 20);
        chk("empty_len", obs.size(), 0);
        chk("empty_done_cyc", done_cyc, 1);
        chk("empty_post", {post_busy, post_pulse}, 2'b00);

        // Timeout: channel 0 masked but never valid; PUSH is entered at cycle 1.
        run_frame(4'b0001, 1'b0, 0, 20);
        chk("to_err_cnt", err_cnt, 1);
        chk("to_err_cyc", err_cyc, 6);
        chk("to_done_cnt", done_cnt, 0);
        chk("to_post", {post_busy, post_pulse}, 2'b00);
        qb[1] = '{9'h15A};
        run_frame(4'b0010, 1'b1, 0, 20);
        crc = crc_ref(16'hFFFF, 8'h5A);
        exp_q = '{9'h05A};
        exp_q.push_back({1'b0, crc[15:8]});
        exp_q.push_back({1'b1, crc[7:0]});
        cmp_obs("after_to");
        chk("after_to_done", done_cnt, 1);

        // Reset pulse in the middle of a stalled PUSH.
        qb[0] = '{9'h0AA, 9'h1BB};
        @(negedge clk);
        start = 1'b1; ch_mask = 4'b0001; crc_en = 1'b1; out_ready = 1'b0;
        drive_lanes();
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        #1 chk("mid_busy_pre", busy, 1);
        #2 rstn = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_out_valid", out_valid, 0);
        chk("mid_pulse", {done, err}, 2'b00);
        @(negedge clk);
        rstn = 1'b1;
        saw = 1'b0;
        repeat (4) begin
            @(negedge clk);
            #1 saw = saw | done | err | busy;
        end
        chk("mid_after", saw, 0);
        for (int k = 0; k < 4; k++) qb[k].delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
